instr_cycle_controller: RTL and testbench
=========================================

# instr_cycle_controller

Instruction-cycle controller for the 8-bit CPU. It steps the one-hot fetch/decode/execute/increment phase sequence and converts the phase plus the current opcode into datapath strobes (IR load, ALU enable, accumulator load, PC increment/load). It also runs a ready/request handshake with the memory interface and halts the CPU on a HALT opcode or on a memory timeout. It sits between the instruction register/flag logic and the PC, accumulator, ALU and memory port.

## Interface
- `TIMEOUT`, default 15: consecutive enabled not-ready cycles allowed in one memory wait before a bus error; legal range 1..255.
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `clear`  in  1  reset, synchronous and active-high; priority over everything.
- `clock_enable`  in  1  advance enable; when low, all state holds.
- `opcode`  in  4  instruction-register output; sampled in DECODE.
- `zero_flag`  in  1  accumulator zero flag; sampled in INCREMENT.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `fetch`, `decode`, `execute`, `increment`  out  1 each  one-hot phase indicators (registered).
- `mem_req`  out  1  memory request (read unless `mem_write`).
- `mem_write`  out  1  write qualifier for `mem_req`.
- `ir_load`, `alu_en`, `acc_load`, `pc_inc`, `pc_load`  out  1 each  single-cycle datapath strobes.
- `halted`  out  1  CPU stopped (registered).
- `bus_error`  out  1  stop was caused by a timeout (registered).

## Operation
- States: FETCH, DECODE, EXECUTE, INCREMENT, HALT. Phase outputs are one-hot in the first four states and all 0 in HALT. `halted` is 1 only in HALT.
- Opcodes:
  - 0x1 LOAD: memory read into accumulator.
  - 0x2 STORE: memory write.
  - 0x3 ADD: ALU operation into accumulator.
  - 0x4 JMP: unconditional jump.
  - 0x5 JZ: jump if zero.
  - 0xF HALT: stop.
  - Everything else (including 0x0) is NOP.
- FETCH:
  - `mem_req`=1, `mem_write`=0.
  - `ir_load` = `mem_ready` & `clock_enable`.
  - Moves to DECODE on an enabled edge with `mem_ready`=1.
- DECODE:
  - Lasts one enabled cycle and latches `opcode` into internal `op_q`.
  - Next state is HALT if `opcode`=0xF (`bus_error` stays 0); otherwise EXECUTE.
- EXECUTE:
  - LOAD: `mem_req`=1; `acc_load` = `mem_ready` & `clock_enable`; waits for `mem_ready`.
  - STORE: `mem_req`=1, `mem_write`=1; waits for `mem_ready`.
  - ADD: `alu_en`=1 and `acc_load`=`clock_enable`, for one cycle.
  - JMP, JZ, NOP: one cycle, no strobes.
  - Then INCREMENT.
- INCREMENT:
  - If `op_q`=JMP, or `op_q`=JZ and `zero_flag`=1: `pc_load`=`clock_enable`.
  - Otherwise: `pc_inc`=`clock_enable`.
  - Exactly one of the two is high. Next state is FETCH.
- HALT: absorbing; only `clear` exits.
- Timeout counter `wait_cnt` (8 bits):
  - Cleared on every state entry.
  - In a wait state (FETCH; EXECUTE with LOAD/STORE), each enabled edge with `mem_ready`=0 does one of two things:
    - if `wait_cnt` = `TIMEOUT`-1: go to HALT and set `bus_error`=1;
    - else increment `wait_cnt`.
  - `mem_ready`=1 on that same edge wins: normal progress, no error.
- Strobes (`ir_load`, `alu_en`, `acc_load`, `pc_inc`, `pc_load`) are combinational from state, `op_q`, `mem_ready`, `zero_flag` and `clock_enable`. All are forced to 0 when `clock_enable`=0 or `clear`=1.
- `mem_req`/`mem_write` depend only on state and `op_q`. They stay asserted through `clock_enable`=0 stalls.

## Timing
- Reset state after an edge with `clear`=1:
  - FETCH; `fetch`=1; `decode`=`execute`=`increment`=0.
  - `halted`=0, `bus_error`=0, `op_q`=0, `wait_cnt`=0.
  - This holds from any state, including mid-wait and HALT.
- Minimum instruction time is 4 enabled cycles (memory ready on first request). Each memory wait adds 1 cycle per not-ready enabled cycle.
- A `clock_enable`=0 cycle freezes state, `wait_cnt`, `op_q` and flags. It does not count toward the timeout.
- `mem_ready` is ignored outside wait states.
- `opcode` is ignored outside DECODE.
- `zero_flag` is ignored outside INCREMENT.
- HALT is entered on the edge that leaves DECODE with 0xF, or on the timeout edge. `halted` reads 1 from the next cycle.

## Test plan
- Reset, then ADD with `mem_ready`=1, `clock_enable`=1 → phases F,D,E,I over 4 cycles:
  - `ir_load` high in F;
  - `alu_en`/`acc_load` high in E;
  - `pc_inc` high in I;
  - back in F on cycle 5.
- LOAD with `mem_ready` low for 2 cycles in both FETCH and EXECUTE → instruction takes 8 cycles; `acc_load` pulses once, on the ready cycle; `bus_error`=0.
- JZ, first with `zero_flag`=1 and then with 0 → `pc_load`=1/`pc_inc`=0, then `pc_inc`=1/`pc_load`=0; JMP → `pc_load`=1 regardless of the flag.
- Both halt causes, each followed by `clear`=1 → FETCH, `halted`=0, `bus_error`=0:
  - Opcode 0xF → `halted`=1 and `bus_error`=0 after DECODE; phases all 0; holds for 20 cycles.
  - `TIMEOUT`=3 with `mem_ready`=0 in FETCH → HALT after 3 enabled cycles, `bus_error`=1.
- `clock_enable`=0 for 5 cycles mid-STORE wait → state and `wait_cnt` frozen, `mem_req`/`mem_write` stay 1, no strobes; resumes normally.
- `clear`=1 asserted during EXECUTE with `clock_enable`=0 → FETCH on the next edge.

Source files
------------

// File: rtl/instr_cycle_controller.sv
// Fetch/decode/execute/increment sequencer: strobes are combinational, phases/halt/bus_error registered.
// Memory waits stretch FETCH and LOAD/STORE EXECUTE until mem_ready; clock_enable=0 freezes everything.
module instr_cycle_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       clock_enable,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       fetch,
    output logic       decode,
    output logic       execute,
    output logic       increment,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_load,
    output logic       alu_en,
    output logic       acc_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       halted,
    output logic       bus_error
);

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_JMP   = 4'h4;
    localparam logic [3:0] OP_JZ    = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    // One-hot encoding so the phase and halt outputs come straight off flops.
    typedef enum logic [4:0] {
        S_FETCH     = 5'b00001,
        S_DECODE    = 5'b00010,
        S_EXECUTE   = 5'b00100,
        S_INCREMENT = 5'b01000,
        S_HALT      = 5'b10000
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] op_q;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       bus_error_nxt;
    logic       adv;
    logic       op_is_mem;
    logic       wait_state;
    logic       timed_out;
    logic       take_jump;

    assign fetch     = state[0];
    assign decode    = state[1];
    assign execute   = state[2];
    assign increment = state[3];
    assign halted    = state[4];

    always_comb begin
        adv        = clock_enable & ~clear;
        op_is_mem  = (op_q == OP_LOAD) | (op_q == OP_STORE);
        wait_state = (state == S_FETCH) | ((state == S_EXECUTE) & op_is_mem);
        timed_out  = wait_state & ~mem_ready & (wait_cnt == WAIT_LIMIT);
        take_jump  = (op_q == OP_JMP) | ((op_q == OP_JZ) & zero_flag);

        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)      state_nxt = S_DECODE;
                else if (timed_out) state_nxt = S_HALT;
            end
            S_DECODE:    state_nxt = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                if (!op_is_mem || mem_ready) state_nxt = S_INCREMENT;
                else if (timed_out)          state_nxt = S_HALT;
            end
            S_INCREMENT: state_nxt = S_FETCH;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_FETCH;
        endcase

        // Counter restarts on every state entry, so each wait gets a fresh budget.
        wait_cnt_nxt = wait_cnt;
        if (state_nxt != state)
            wait_cnt_nxt = 8'd0;
        else if (wait_state && !mem_ready)
            wait_cnt_nxt = wait_cnt + 8'd1;

        bus_error_nxt = bus_error | timed_out;

        mem_req   = wait_state;
        mem_write = (state == S_EXECUTE) & (op_q == OP_STORE);
        ir_load   = adv & (state == S_FETCH) & mem_ready;
        alu_en    = adv & (state == S_EXECUTE) & (op_q == OP_ADD);
        acc_load  = adv & (state == S_EXECUTE) &
                    (((op_q == OP_LOAD) & mem_ready) | (op_q == OP_ADD));
        pc_load   = adv & (state == S_INCREMENT) & take_jump;
        pc_inc    = adv & (state == S_INCREMENT) & ~take_jump;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= S_FETCH;
            op_q      <= 4'h0;
            wait_cnt  <= 8'd0;
            bus_error <= 1'b0;
        end else if (clock_enable) begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            bus_error <= bus_error_nxt;
            if (state == S_DECODE)
                op_q <= opcode;
        end
    end

endmodule

// File: tb/tb_instr_cycle_controller.sv
// Directed plus random stimulus against a phase-level reference model of the instruction cycle.
module tb_instr_cycle_controller;

    localparam int TO = 3;

    logic       clock = 1'b0;
    logic       clear, clock_enable, zero_flag, mem_ready;
    logic [3:0] opcode;
    logic       fetch, decode, execute, increment, mem_req, mem_write;
    logic       ir_load, alu_en, acc_load, pc_inc, pc_load, halted, bus_error;

    int n_asserts = 0;
    int n_fails   = 0;

    // Model: phase 0=F 1=D 2=E 3=I 4=HALT
    int m_ph   = 0;
    int m_op   = 0;
    int m_wcnt = 0;
    bit m_berr = 1'b0;
    bit m_valid = 1'b0;

    instr_cycle_controller #(.TIMEOUT(TO)) dut (
        .clock(clock), .clear(clear), .clock_enable(clock_enable),
        .opcode(opcode), .zero_flag(zero_flag), .mem_ready(mem_ready),
        .fetch(fetch), .decode(decode), .execute(execute), .increment(increment),
        .mem_req(mem_req), .mem_write(mem_write), .ir_load(ir_load),
        .alu_en(alu_en), .acc_load(acc_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .halted(halted), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    function automatic logic [12:0] model_out(input logic ce, input logic clr,
                                              input logic rdy, input logic zf);
        logic en, memop, jump;
        en    = ce && !clr;
        memop = (m_op == 1) || (m_op == 2);
        jump  = (m_op == 4) || (m_op == 5 && zf);
        return {m_ph == 0, m_ph == 1, m_ph == 2, m_ph == 3, m_ph == 4, m_berr,
                (m_ph == 0) || (m_ph == 2 && memop),
                m_ph == 2 && m_op == 2,
                en && m_ph == 0 && rdy,
                en && m_ph == 2 && m_op == 3,
                en && m_ph == 2 && ((m_op == 1 && rdy) || m_op == 3),
                en && m_ph == 3 && !jump,
                en && m_ph == 3 && jump};
    endfunction

    task automatic model_advance(input logic ce, input logic clr, input logic rdy,
                                 input logic [3:0] opc);
        int nxt;
        if (clr) begin
            m_ph = 0; m_op = 0; m_wcnt = 0; m_berr = 1'b0; m_valid = 1'b1;
            return;
        end
        if (!ce) return;
        nxt = m_ph;
        if (m_ph == 0 || (m_ph == 2 && (m_op == 1 || m_op == 2))) begin
            if (rdy) nxt = m_ph + 1;
            else if (m_wcnt == TO - 1) begin nxt = 4; m_berr = 1'b1; end
            else m_wcnt++;
        end else if (m_ph == 1) begin
            m_op = int'(opc);
            nxt  = (opc == 4'hF) ? 4 : 2;
        end else if (m_ph == 2) begin
            nxt = 3;
        end else if (m_ph == 3) begin
            nxt = 0;
        end
        if (nxt != m_ph) m_wcnt = 0;
        m_ph = nxt;
    endtask

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ce, input logic clr, input logic rdy, input logic zf,
                        input logic [3:0] opc, input string tag);
        clock_enable = ce; clear = clr; mem_ready = rdy; zero_flag = zf; opcode = opc;
        #1;
        if (m_valid)
            check(tag, {fetch, decode, execute, increment, halted, bus_error, mem_req,
                        mem_write, ir_load, alu_en, acc_load, pc_inc, pc_load},
                  model_out(ce, clr, rdy, zf));
        @(posedge clock);
        model_advance(ce, clr, rdy, opc);
        @(negedge clock);
    endtask

    initial begin
        logic ce, clr, rdy, zf;
        logic [3:0] opc;

        step(1, 1, 0, 0, 4'h0, "reset");
        check("rst_state", {8'b0, fetch, decode, execute, increment, halted}, 13'b1_0000);
        check("rst_flags", {11'b0, bus_error, mem_write}, 13'd0);

        // ADD, memory always ready: four cycles
        step(1, 0, 1, 0, 4'h0, "add_f");
        step(1, 0, 1, 0, 4'h3, "add_d");
        step(1, 0, 1, 0, 4'h0, "add_e");
        step(1, 0, 1, 0, 4'h0, "add_i");
        check("add_back_in_fetch", {12'b0, fetch}, 13'd1);

        // LOAD with two not-ready cycles in both waits
        step(1, 0, 0, 0, 4'h0, "load_f_w0");
        step(1, 0, 0, 0, 4'h0, "load_f_w1");
        step(1, 0, 1, 0, 4'h0, "load_f_rdy");
        step(1, 0, 1, 0, 4'h1, "load_d");
        step(1, 0, 0, 0, 4'h0, "load_e_w0");
        step(1, 0, 0, 0, 4'h0, "load_e_w1");
        step(1, 0, 1, 0, 4'h0, "load_e_rdy");
        step(1, 0, 1, 0, 4'h0, "load_i");
        check("load_no_berr", {11'b0, bus_error, fetch}, 13'd1);

        // JZ taken, JZ not taken, JMP with flag clear
        step(1, 0, 1, 0, 4'h0, "jz1_f"); step(1, 0, 1, 0, 4'h5, "jz1_d");
        step(1, 0, 1, 0, 4'h0, "jz1_e"); step(1, 0, 1, 1, 4'h0, "jz1_i");
        step(1, 0, 1, 0, 4'h0, "jz0_f"); step(1, 0, 1, 0, 4'h5, "jz0_d");
        step(1, 0, 1, 1, 4'h0, "jz0_e"); step(1, 0, 1, 0, 4'h0, "jz0_i");
        step(1, 0, 1, 0, 4'h0, "jmp_f"); step(1, 0, 1, 0, 4'h4, "jmp_d");
        step(1, 0, 1, 0, 4'h0, "jmp_e"); step(1, 0, 1, 0, 4'h0, "jmp_i");

        // HALT opcode, held for 20 cycles, then clear
        step(1, 0, 1, 0, 4'h0, "hlt_f");
        step(1, 0, 1, 0, 4'hF, "hlt_d");
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "hlt_hold");
        check("hlt_outputs", {7'b0, fetch, decode, execute, increment, halted, bus_error},
              13'b00_0010);
        step(1, 1, 0, 0, 4'h0, "hlt_clear");
        check("hlt_cleared", {10'b0, fetch, halted, bus_error}, 13'b100);

        // Timeout in FETCH after TO enabled not-ready cycles
        for (int i = 0; i < TO; i++) step(1, 0, 0, 0, 4'h0, "to_wait");
        check("to_halted", {11'b0, halted, bus_error}, 13'b11);
        step(1, 0, 1, 0, 4'h0, "to_hold");
        step(1, 1, 0, 0, 4'h0, "to_clear");
        check("to_cleared", {10'b0, fetch, halted, bus_error}, 13'b100);

        // STORE wait with a 5-cycle stall in the middle; stall must not count
        step(1, 0, 1, 0, 4'h0, "st_f"); step(1, 0, 1, 0, 4'h2, "st_d");
        step(1, 0, 0, 0, 4'h0, "st_w0");
        step(1, 0, 0, 0, 4'h0, "st_w1");
        for (int i = 0; i < 5; i++)
            step(0, 0, 1'($urandom_range(0, 1)), 0, 4'h0, "st_stall");
        step(1, 0, 1, 0, 4'h0, "st_rdy");
        step(1, 0, 1, 0, 4'h0, "st_i");
        check("st_resumed", {11'b0, fetch, bus_error}, 13'b10);

        // Clear during a stalled EXECUTE
        step(1, 0, 1, 0, 4'h0, "clr_f"); step(1, 0, 1, 0, 4'h3, "clr_d");
        step(0, 1, 1, 0, 4'h0, "clr_e");
        check("clr_to_fetch", {12'b0, fetch}, 13'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            ce  = 1'($urandom_range(0, 9) < 8);
            clr = (m_ph == 4) ? 1'($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 59) == 0);
            rdy = 1'($urandom_range(0, 9) < 6);
            zf  = 1'($urandom_range(0, 1));
            opc = 4'($urandom_range(0, 15));
            step(ce, clr, rdy, zf, opc, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
